// File: rtl/bsg_test_node_pkg.sv
// Shared types and field-offset helpers for the framed test-node ring client.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bsg_test_node_pkg;

  // Inbound assembler: waiting for beat 0, collecting beats 1..N-1, holding a full message.
  typedef enum logic [1:0] {
    eIDLE    = 2'd0,
    eCOLLECT = 2'd1,
    eHOLD    = 2'd2
  } in_state_e;

  // Outbound serializer: no frame loaded, or streaming beats.
  typedef enum logic {
    eEMPTY = 1'b0,
    eSEND  = 1'b1
  } out_state_e;

  // Frame and error counters are 16 bits and wrap.
  localparam int ctr_width_c = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Beat index width. The floor of 2 keeps it at least one bit wide even
  // when both directions use a single beat.
  function automatic int calc_idx_width(input int els_in, input int els_out);
    return $clog2(max2(max2(els_in, els_out), 2));
  endfunction

  // Beat index sits directly above the payload.
  function automatic int idx_lsb(input int beat_w);
    return beat_w;
  endfunction

  // Client ID occupies the MSBs of a ring word.
  function automatic int id_lsb(input int ring_w, input int id_w);
    return ring_w - id_w;
  endfunction

endpackage

// File: rtl/bsg_test_node_beat_serializer.sv
// Outbound buffer: holds one result and streams it as tagged ring beats, low slice first.
// Latency: v_o rises the cycle after load_v_i; one beat per yumi_i.
// Backpressure: loads only while empty_o; a beat holds until yumi_i; one bubble after the last beat.
//
// Ports: clk_i/reset_n_i; load_v_i/load_data_i (load port, sampled only when
// empty_o); v_o/data_o/yumi_i (ring side); empty_o; frames_o (sent frames, wrapping).
module bsg_test_node_beat_serializer
  import bsg_test_node_pkg::*;
#(
  parameter int ring_width_p = 81,
  parameter int id_width_p   = 4,
  parameter int client_id_p  = 0,
  parameter int beat_width_p = 75,
  parameter int els_out_p    = 3,
  parameter int out_width_p  = 178,
  parameter int idx_width_p  = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    load_v_i,
  input  logic [out_width_p-1:0]  load_data_i,
  output logic                    empty_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic [15:0]             frames_o
);

  localparam int buf_w_lp   = els_out_p * beat_width_p;
  localparam int idx_lsb_lp = idx_lsb(beat_width_p);
  localparam int id_lsb_lp  = id_lsb(ring_width_p, id_width_p);
  localparam logic [idx_width_p-1:0] last_cnt_lp = idx_width_p'(els_out_p - 1);

  out_state_e              r_state;
  logic [idx_width_p-1:0]  r_cnt;
  logic [buf_w_lp-1:0]     r_buf;
  logic [ctr_width_c-1:0]  r_frames;

  logic [beat_width_p-1:0] w_slice;
  logic [ring_width_p-1:0] w_dat;

  assign empty_o  = (r_state == eEMPTY);
  assign v_o      = (r_state == eSEND);
  assign frames_o = r_frames;
  assign data_o   = w_dat;

  // Ring word: {client ID, zero pad, beat index, payload slice}; all zero when idle.
  always_comb begin
    w_slice = r_buf[int'(r_cnt) * beat_width_p +: beat_width_p];
    w_dat   = '0;
    if (r_state == eSEND) begin
      w_dat[id_lsb_lp +: id_width_p]   = id_width_p'(client_id_p);
      w_dat[idx_lsb_lp +: idx_width_p] = r_cnt;
      w_dat[beat_width_p-1:0]          = w_slice;
    end
  end

  // The last beat returns to eEMPTY; empty_o is only seen next cycle, which
  // yields the single-cycle bubble between frames.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= eEMPTY;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_frames <= '0;
    end else begin
      case (r_state)
        eEMPTY: begin
          if (load_v_i) begin
            r_buf   <= buf_w_lp'(load_data_i);
            r_cnt   <= '0;
            r_state <= eSEND;
          end
        end
        eSEND: begin
          if (yumi_i) begin
            if (r_cnt == last_cnt_lp) begin
              r_cnt    <= '0;
              r_state  <= eEMPTY;
              r_frames <= r_frames + 16'd1;
            end else begin
              r_cnt <= r_cnt + idx_width_p'(1);
            end
          end
        end
        default: r_state <= eEMPTY;
      endcase
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: rtl/bsg_test_node_client_framed.sv
// Ring client: assembles indexed ring beats into a core message, serialises core results (or a loopback copy) back out.
// Latency: message valid the cycle after its last beat; outbound beat valid the cycle after the load.
// Backpressure: ready_o low while a message is held or en_i=0; core results wait for an empty outbound buffer.
//
// Ports: clk_i/reset_n_i; en_i enable; mode_i (1=loopback, sampled with beat 0);
// v_i/data_i/ready_o inbound ring; v_o/data_o/yumi_i outbound ring;
// core_v_o/core_data_o/core_ready_i message to core; core_v_i/core_data_i/core_yumi_o
// result from core; frames_in_o/frames_out_o/err_cnt_o wrapping counters.
module bsg_test_node_client_framed
  import bsg_test_node_pkg::*;
#(
  parameter int ring_width_p = 81,
  parameter int id_width_p   = 4,
  parameter int client_id_p  = 0,
  parameter int beat_width_p = 75,
  parameter int els_in_p     = 3,
  parameter int els_out_p    = 3,
  parameter int in_width_p   = 178,
  parameter int out_width_p  = 178
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    mode_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic                    core_v_o,
  output logic [in_width_p-1:0]   core_data_o,
  input  logic                    core_ready_i,
  input  logic                    core_v_i,
  input  logic [out_width_p-1:0]  core_data_i,
  output logic                    core_yumi_o,
  output logic [15:0]             frames_in_o,
  output logic [15:0]             frames_out_o,
  output logic [15:0]             err_cnt_o
);

  localparam int idx_width_lp = calc_idx_width(els_in_p, els_out_p);
  localparam int in_buf_w_lp  = els_in_p * beat_width_p;
  localparam int lb_copy_w_lp = min2(in_width_p, out_width_p);
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(els_in_p - 1);

  // r_run is 0 until the first clock after reset release, so every handshake
  // output stays low through reset regardless of the other inputs.
  logic                    r_run;
  in_state_e               r_in_state;
  logic [idx_width_lp-1:0] r_exp_idx;
  logic [in_buf_w_lp-1:0]  r_in_buf;
  logic                    r_lb_mode;
  logic [ctr_width_c-1:0]  r_frames_in;
  logic [ctr_width_c-1:0]  r_err_cnt;

  logic [idx_width_lp-1:0] w_idx;
  logic [beat_width_p-1:0] w_pay;
  logic                    w_hold;
  logic                    w_accept;
  logic                    w_lb_pending;
  logic                    w_lb_load;
  logic                    w_core_hs;
  logic                    w_out_empty;
  logic                    w_load_v;
  logic [out_width_p-1:0]  w_lb_data;
  logic [out_width_p-1:0]  w_load_data;
  logic                    w_unused_bits;

  assign w_pay = data_i[beat_width_p-1:0];
  assign w_idx = data_i[idx_lsb(beat_width_p) +: idx_width_lp];

  assign w_hold      = (r_in_state == eHOLD);
  assign ready_o     = en_i & r_run & ~w_hold;
  assign w_accept    = v_i & ready_o;

  assign w_lb_pending = w_hold & r_lb_mode;
  assign core_v_o     = w_hold & ~r_lb_mode;
  assign core_data_o  = r_in_buf[in_width_p-1:0];
  assign w_core_hs    = core_v_o & core_ready_i;

  // A held loopback frame owns the empty outbound buffer; core results wait behind it.
  assign w_lb_load   = w_lb_pending & w_out_empty & en_i & r_run;
  assign core_yumi_o = core_v_i & w_out_empty & en_i & r_run & ~w_lb_pending;
  assign w_load_v    = w_lb_load | core_yumi_o;
  assign w_load_data = w_lb_load ? w_lb_data : core_data_i;

  // Loopback sends the in_width_p-bit message, truncated or zero-extended to the result width.
  always_comb begin
    w_lb_data = '0;
    w_lb_data[lb_copy_w_lp-1:0] = r_in_buf[lb_copy_w_lp-1:0];
  end

  // Ring tag bits and message bits beyond in_width_p are deliberately ignored.
  assign w_unused_bits = ^{data_i, r_in_buf};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_run       <= 1'b0;
      r_in_state  <= eIDLE;
      r_exp_idx   <= '0;
      r_in_buf    <= '0;
      r_lb_mode   <= 1'b0;
      r_frames_in <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        if (w_idx == r_exp_idx) begin
          for (int k = 0; k < els_in_p; k++) begin
            if (w_idx == idx_width_lp'(k)) begin
              r_in_buf[k*beat_width_p +: beat_width_p] <= w_pay;
            end
          end
          if (w_idx == '0) begin
            r_lb_mode <= mode_i;
          end
          if (w_idx == last_idx_lp) begin
            r_in_state  <= eHOLD;
            r_exp_idx   <= '0;
            r_frames_in <= r_frames_in + 16'd1;
          end else begin
            r_in_state <= eCOLLECT;
            r_exp_idx  <= r_exp_idx + idx_width_lp'(1);
          end
        end else begin
          // Out-of-sequence beat: drop the partial frame. An index of 0
          // is taken as the start of a fresh frame rather than thrown away.
          r_err_cnt <= r_err_cnt + 16'd1;
          if (w_idx == '0) begin
            r_in_buf[beat_width_p-1:0] <= w_pay;
            r_lb_mode  <= mode_i;
            r_exp_idx  <= idx_width_lp'(1);
            r_in_state <= eCOLLECT;
          end else begin
            r_exp_idx  <= '0;
            r_in_state <= eIDLE;
          end
        end
      end else if (w_core_hs || w_lb_load) begin
        r_in_state <= eIDLE;
      end
    end
  end

  assign frames_in_o = r_frames_in;
  assign err_cnt_o   = r_err_cnt;

  bsg_test_node_beat_serializer #(
    .ring_width_p (ring_width_p),
    .id_width_p   (id_width_p),
    .client_id_p  (client_id_p),
    .beat_width_p (beat_width_p),
    .els_out_p    (els_out_p),
    .out_width_p  (out_width_p),
    .idx_width_p  (idx_width_lp)
  ) u_ser (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .load_v_i    (w_load_v),
    .load_data_i (w_load_data),
    .empty_o     (w_out_empty),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .frames_o    (frames_out_o)
  );

endmodule

// File: tb/tb_bsg_test_node_client_framed.sv
// Testbench for bsg_test_node_client_framed: directed scenarios plus a random phase,
// every cycle compared against a transaction-level reference model.
// Ports: drives every DUT input; yumi_i is the gated consume of the current beat.
module tb_bsg_test_node_client_framed;

  localparam int RW   = 81;
  localparam int IW   = 4;
  localparam int CID  = 9;
  localparam int BW   = 75;
  localparam int EI   = 3;
  localparam int EO   = 3;
  localparam int INW  = 178;
  localparam int OUTW = 178;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            en_i;
  logic            mode_i;
  logic            v_i;
  logic [RW-1:0]   data_i;
  logic            ready_o;
  logic            v_o;
  logic [RW-1:0]   data_o;
  wire             yumi_i;
  logic            core_v_o;
  logic [INW-1:0]  core_data_o;
  logic            core_ready_i;
  logic            core_v_i;
  logic [OUTW-1:0] core_data_i;
  logic            core_yumi_o;
  logic [15:0]     frames_in_o;
  logic [15:0]     frames_out_o;
  logic [15:0]     err_cnt_o;

  logic yumi_en;
  logic core_gen;
  assign yumi_i = yumi_en & v_o;

  always #5 clk_i = ~clk_i;

  bsg_test_node_client_framed #(
    .ring_width_p(RW), .id_width_p(IW), .client_id_p(CID), .beat_width_p(BW),
    .els_in_p(EI), .els_out_p(EO), .in_width_p(INW), .out_width_p(OUTW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .mode_i(mode_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .core_v_o(core_v_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
    .core_v_i(core_v_i), .core_data_i(core_data_i), .core_yumi_o(core_yumi_o),
    .frames_in_o(frames_in_o), .frames_out_o(frames_out_o), .err_cnt_o(err_cnt_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_run;
  bit            m_hold;
  bit            m_mode;
  int            m_exp;
  logic [BW-1:0] m_frame [EI];
  int            m_fin, m_fout, m_err;
  logic [RW-1:0] m_out_q [$];

  task automatic model_reset();
    m_run = 0; m_hold = 0; m_mode = 0; m_exp = 0;
    m_fin = 0; m_fout = 0; m_err = 0;
    for (int k = 0; k < EI; k++) m_frame[k] = '0;
    m_out_q.delete();
  endtask

  function automatic logic [INW-1:0] frame_msg();
    logic [EI*BW-1:0] w;
    for (int k = 0; k < EI; k++) w[k*BW +: BW] = m_frame[k];
    return w[INW-1:0];
  endfunction

  task automatic push_frame(input logic [OUTW-1:0] msg);
    logic [EO*BW-1:0] w;
    logic [RW-1:0]    b;
    w = '0;
    w[OUTW-1:0] = msg;
    for (int k = 0; k < EO; k++) begin
      b = '0;
      b[RW-1 -: IW] = IW'(CID);
      b[BW +: 2]    = 2'(k);
      b[BW-1:0]     = w[k*BW +: BW];
      m_out_q.push_back(b);
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the coming edge.
  task automatic model_step();
    bit out_empty, exp_rdy, exp_cv, exp_cy, lb_load;
    logic [INW-1:0] msg;
    int idx;
    out_empty = (m_out_q.size() == 0);
    exp_rdy   = en_i && m_run && !m_hold;
    exp_cv    = m_hold && !m_mode;
    exp_cy    = core_v_i && out_empty && en_i && m_run && !(m_hold && m_mode);
    lb_load   = m_hold && m_mode && out_empty && en_i && m_run;
    msg       = frame_msg();

    check_val("ready_o", ready_o, exp_rdy);
    check_val("core_v_o", core_v_o, exp_cv);
    if (exp_cv) check_val("core_data_o", core_data_o, msg);
    check_val("core_yumi_o", core_yumi_o, exp_cy);
    check_val("v_o", v_o, !out_empty);
    if (!out_empty) check_val("data_o", data_o, m_out_q[0]);
    check_val("frames_in_o", frames_in_o, 16'(m_fin));
    check_val("frames_out_o", frames_out_o, 16'(m_fout));
    check_val("err_cnt_o", err_cnt_o, 16'(m_err));

    if (v_i && exp_rdy) begin
      idx = int'(data_i[BW +: 2]);
      if (idx == m_exp) begin
        m_frame[idx] = data_i[BW-1:0];
        if (idx == 0) m_mode = mode_i;
        if (idx == EI-1) begin
          m_hold = 1; m_fin++; m_exp = 0;
        end else begin
          m_exp++;
        end
      end else begin
        m_err++;
        if (idx == 0) begin
          m_frame[0] = data_i[BW-1:0]; m_mode = mode_i; m_exp = 1;
        end else begin
          m_exp = 0;
        end
      end
    end
    if (exp_cv && core_ready_i) m_hold = 0;
    if (lb_load) begin
      push_frame(OUTW'(msg));
      m_hold = 0;
    end
    if (exp_cy) push_frame(core_data_i);
    if (!out_empty && yumi_en) begin
      void'(m_out_q.pop_front());
      if (m_out_q.size() == 0) m_fout++;
    end
    m_run = 1;
  endtask

  initial begin : checker_proc
    forever begin
      @(negedge clk_i);
      if (reset_n_i) model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [OUTW-1:0] rand_wide();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[OUTW-1:0];
  endfunction

  function automatic logic [BW-1:0] rand_pay();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[BW-1:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input int idx, input logic [BW-1:0] pay, input bit md);
    int n;
    logic [95:0] junk;
    n = 0;
    junk = {$urandom, $urandom, $urandom};
    data_i = junk[RW-1:0];
    data_i[BW-1:0] = pay;
    data_i[BW +: 2] = 2'(idx);
    mode_i = md;
    v_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (ready_o || n >= 300) break;
      n++;
    end
    @(posedge clk_i); #1;
    if (n >= 300) check_val("send_timeout", 0, 1);
    v_i = 1'b0;
    mode_i = 1'($urandom_range(0, 1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ready_o"}, ready_o, 0);
    check_val({tag, "_v_o"}, v_o, 0);
    check_val({tag, "_data_o"}, data_o, 0);
    check_val({tag, "_core_v_o"}, core_v_o, 0);
    check_val({tag, "_core_data_o"}, core_data_o, 0);
    check_val({tag, "_core_yumi_o"}, core_yumi_o, 0);
    check_val({tag, "_frames_in_o"}, frames_in_o, 0);
    check_val({tag, "_frames_out_o"}, frames_out_o, 0);
    check_val({tag, "_err_cnt_o"}, err_cnt_o, 0);
  endtask

  // Core result source: holds a result until consumed.
  initial begin : core_drv
    bit consumed;
    core_v_i = 1'b0;
    core_data_i = '0;
    forever begin
      @(negedge clk_i);
      consumed = core_yumi_o;
      @(posedge clk_i); #1;
      if (consumed || !core_v_i || !core_gen) begin
        core_v_i = core_gen && ($urandom_range(0, 1) == 1);
        if (core_v_i) core_data_i = rand_wide();
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main_proc
    bit done;
    int n;
    reset_n_i = 1'b0; en_i = 1'b1; mode_i = 1'b0; v_i = 1'b0; data_i = '0;
    yumi_en = 1'b0; core_ready_i = 1'b0; core_gen = 1'b0;
    model_reset();
    #2;
    check_outputs_zero("reset");
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    // Compute frame; core initially not ready so the message is held.
    send_beat(0, rand_pay(), 0); send_beat(1, rand_pay(), 0); send_beat(2, rand_pay(), 0);
    idle(3);
    core_ready_i = 1'b1;
    idle(2);
    core_gen = 1'b1; yumi_en = 1'b1;
    idle(6);
    core_gen = 1'b0;
    idle(8);

    // Bad index, then a clean frame.
    send_beat(0, rand_pay(), 0); send_beat(2, rand_pay(), 0);
    send_beat(0, rand_pay(), 0); send_beat(1, rand_pay(), 0); send_beat(2, rand_pay(), 0);
    idle(3);

    // Index restart.
    send_beat(0, rand_pay(), 0); send_beat(0, rand_pay(), 0);
    send_beat(1, rand_pay(), 0); send_beat(2, rand_pay(), 0);
    idle(3);

    // Loopback with mode toggled mid-frame.
    send_beat(0, rand_pay(), 1); send_beat(1, rand_pay(), 0); send_beat(2, rand_pay(), 0);
    idle(8);

    // Enable dropped during outbound beat 1 of a loopback frame.
    yumi_en = 1'b0;
    send_beat(0, rand_pay(), 1); send_beat(1, rand_pay(), 1); send_beat(2, rand_pay(), 1);
    n = 0;
    while (!v_o && n < 50) begin idle(1); n++; end
    if (n >= 50) check_val("lb_wait_timeout", 0, 1);
    yumi_en = 1'b1;
    idle(1);
    en_i = 1'b0;
    idle(5);
    en_i = 1'b1;
    idle(2);

    // Asynchronous reset mid-frame, then a clean frame.
    send_beat(0, rand_pay(), 0); send_beat(1, rand_pay(), 0);
    #3;
    reset_n_i = 1'b0;
    #1;
    check_outputs_zero("midreset");
    model_reset();
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    send_beat(0, rand_pay(), 0); send_beat(1, rand_pay(), 0); send_beat(2, rand_pay(), 0);
    idle(6);

    // Random phase.
    done = 1'b0;
    core_gen = 1'b1;
    fork
      begin
        for (int j = 0; j < 360; j++) begin
          int idx;
          idx = j % EI;
          if ($urandom_range(0, 9) == 0) idx = $urandom_range(0, 3);
          send_beat(idx, rand_pay(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_i); #1;
          en_i         = ($urandom_range(0, 9) != 0);
          yumi_en      = ($urandom_range(0, 2) != 0);
          core_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join

    // Drain.
    en_i = 1'b1; yumi_en = 1'b1; core_ready_i = 1'b1; core_gen = 1'b0;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
